// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-order pipeline hazard scoreboard with forwarding select, load-use stall and flush
module pipeline_scoreboard #(
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int FLUSH_STAGES     = 1,
  parameter int CNT_W            = 32,
  localparam int SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd_addr,
  input  logic             issue_rd_we,
  input  logic             issue_is_load,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_rs1_sel,
  output logic [SEL_W-1:0] fwd_rs2_sel,
  output logic             wb_valid,
  output logic             wb_rd_we,
  output logic [4:0]       wb_rd_addr,
  output logic [CNT_W-1:0] stall_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [DEPTH-1:0] load_q, load_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];

  logic             wb_valid_q, wb_rd_we_q;
  logic [4:0]       wb_rd_addr_q;
  logic [CNT_W-1:0] stall_count_q;

  logic [SEL_W-1:0] sel1, sel2;
  logic             hz1, hz2;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    hz1  = 1'b0;
    hz2  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && we_q[k] && rd_q[k] != 5'd0) begin
        if (rs1_used && rd_q[k] == rs1_addr) begin
          sel1 = SEL_W'(k + 1);
          hz1  = load_q[k] && (k < LOAD_READY_STAGE);
        end
        if (rs2_used && rd_q[k] == rs2_addr) begin
          sel2 = SEL_W'(k + 1);
          hz2  = load_q[k] && (k < LOAD_READY_STAGE);
        end
      end
    end
  end

  assign stall       = issue_valid && !flush && (hz1 || hz2);
  assign fwd_rs1_sel = sel1;
  assign fwd_rs2_sel = sel2;

  always_comb begin
    valid_d    = '0;
    we_d       = '0;
    load_d     = '0;
    valid_d[0] = issue_valid && !stall && !flush;
    we_d[0]    = issue_rd_we;
    load_d[0]  = issue_is_load;
    rd_d[0]    = issue_rd_addr;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1] && !(flush && i <= FLUSH_STAGES);
      we_d[i]    = we_q[i-1];
      load_d[i]  = load_q[i-1];
      rd_d[i]    = rd_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      we_q          <= '0;
      load_q        <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= 5'd0;
      wb_valid_q    <= 1'b0;
      wb_rd_we_q    <= 1'b0;
      wb_rd_addr_q  <= 5'd0;
      stall_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      we_q         <= we_d;
      load_q       <= load_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
      wb_valid_q   <= valid_q[DEPTH-1];
      wb_rd_we_q   <= we_q[DEPTH-1];
      wb_rd_addr_q <= rd_q[DEPTH-1];
      if (stall && stall_count_q != {CNT_W{1'b1}})
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd_we    = wb_rd_we_q;
  assign wb_rd_addr  = wb_rd_addr_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - self-checking bench for pipeline_scoreboard
module tb_pipeline_scoreboard;
  localparam int DEPTH = 3;
  localparam int LRS   = 2;
  localparam int FL    = 1;
  localparam int CW    = 4;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int MAXC  = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd_addr = '0;
  logic          issue_rd_we = 1'b0;
  logic          issue_is_load = 1'b0;
  logic [4:0]    rs1_addr = '0, rs2_addr = '0;
  logic          rs1_used = 1'b0, rs2_used = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [SW-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic          wb_valid, wb_rd_we;
  logic [4:0]    wb_rd_addr;
  logic [CW-1:0] stall_count;

  pipeline_scoreboard #(.DEPTH(DEPTH), .LOAD_READY_STAGE(LRS), .FLUSH_STAGES(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr),
    .issue_rd_we(issue_rd_we), .issue_is_load(issue_is_load), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
    .stall(stall), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a log of instructions indexed by the cycle they were accepted.
  // An instruction accepted in cycle n sits in stage (cur-n-1) during cycle cur.
  bit         m_acc  [MAXC];
  bit         m_kill [MAXC];
  bit         m_we   [MAXC];
  bit         m_ld   [MAXC];
  logic [4:0] m_rd   [MAXC];
  int         cur = 0;
  int         start_n = 0;
  int         cnt = 0;

  function automatic bit alive(input int n);
    return n >= 0 && n >= start_n && m_acc[n] && !m_kill[n];
  endfunction

  function automatic int fwd_exp(input logic [4:0] a, input bit used, output bit haz);
    haz = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      int n;
      n = cur - s - 1;
      if (used && a != 5'd0 && alive(n) && m_we[n] && m_rd[n] == a) begin
        haz = m_ld[n] && (s < LRS);
        return s + 1;
      end
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall", int'(stall), 0);
      chk("rst_fwd1", int'(fwd_rs1_sel), 0);
      chk("rst_fwd2", int'(fwd_rs2_sel), 0);
      chk("rst_wb_valid", int'(wb_valid), 0);
      chk("rst_wb_rd_we", int'(wb_rd_we), 0);
      chk("rst_wb_rd_addr", int'(wb_rd_addr), 0);
      chk("rst_stall_count", int'(stall_count), 0);
      m_acc[cur] = 1'b0;
      start_n = cur + 1;
      cnt = 0;
    end else begin
      bit h1, h2, est, ewb;
      int e1, e2, nw;
      e1  = fwd_exp(rs1_addr, rs1_used, h1);
      e2  = fwd_exp(rs2_addr, rs2_used, h2);
      est = issue_valid && !flush && (h1 || h2);
      chk("stall", int'(stall), int'(est));
      chk("fwd_rs1_sel", int'(fwd_rs1_sel), e1);
      chk("fwd_rs2_sel", int'(fwd_rs2_sel), e2);
      nw  = cur - DEPTH - 1;
      ewb = alive(nw);
      chk("wb_valid", int'(wb_valid), int'(ewb));
      if (ewb) begin
        chk("wb_rd_we", int'(wb_rd_we), int'(m_we[nw]));
        chk("wb_rd_addr", int'(wb_rd_addr), int'(m_rd[nw]));
      end
      chk("stall_count", int'(stall_count), cnt);
      m_acc[cur] = issue_valid && !est && !flush;
      m_rd[cur]  = issue_rd_addr;
      m_we[cur]  = issue_rd_we;
      m_ld[cur]  = issue_is_load;
      if (flush)
        for (int s = 0; s < FL; s++)
          if (cur - s - 1 >= 0) m_kill[cur - s - 1] = 1'b1;
      if (est && cnt < (1 << CW) - 1) cnt++;
    end
    cur++;
    if (cur >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cur, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
  end

  task automatic drive(input bit iv, input logic [4:0] rd, input bit we, input bit ld,
                       input logic [4:0] a1, input bit u1, input logic [4:0] a2, input bit u2,
                       input bit fl);
    @(posedge clk);
    #1;
    issue_valid = iv; issue_rd_addr = rd; issue_rd_we = we; issue_is_load = ld;
    rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2; flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #7;
    chk("reset_stall", int'(stall), 0);
    chk("reset_fwd1", int'(fwd_rs1_sel), 0);
    chk("reset_wb_valid", int'(wb_valid), 0);
    chk("reset_stall_count", int'(stall_count), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    #1 chk("alu_fwd1", int'(fwd_rs1_sel), 1);
    chk("alu_stall", int'(stall), 0);
    idle(5);

    drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 7, 1, 0);
    #1 chk("lu_stall_a", int'(stall), 1);
    drive(1, 1, 1, 0, 0, 0, 7, 1, 0);
    #1 chk("lu_stall_b", int'(stall), 1);
    drive(1, 1, 1, 0, 0, 0, 7, 1, 0);
    #1 chk("lu_stall_c", int'(stall), 0);
    chk("lu_fwd2", int'(fwd_rs2_sel), 3);
    chk("lu_count", int'(stall_count), 2);
    idle(5);

    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0);
    #1 chk("youngest_fwd1", int'(fwd_rs1_sel), 1);
    idle(5);

    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("r0_fwd1", int'(fwd_rs1_sel), 0);
    chk("r0_stall", int'(stall), 0);
    idle(5);

    drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 11, 1, 1, 0, 0, 0, 0, 0);
    drive(1, 12, 1, 0, 11, 1, 0, 0, 1);
    #1 chk("flush_stall", int'(stall), 0);
    drive(1, 13, 1, 0, 10, 1, 11, 1, 0);
    #1 chk("flush_survivor_fwd1", int'(fwd_rs1_sel), 3);
    chk("flush_killed_fwd2", int'(fwd_rs2_sel), 0);
    idle(1);
    #1 chk("flush_wb_valid", int'(wb_valid), 1);
    chk("flush_wb_rd", int'(wb_rd_addr), 10);
    idle(5);

    repeat (30) drive(1, 7, 1, 1, 7, 1, 0, 0, 0);
    #1 chk("sat_count", int'(stall_count), 15);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("pulse_stall", int'(stall), 0);
    chk("pulse_fwd1", int'(fwd_rs1_sel), 0);
    chk("pulse_count", int'(stall_count), 0);
    chk("pulse_wb_valid", int'(wb_valid), 0);
    chk("pulse_wb_rd", int'(wb_rd_addr), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("post_rst_stall", int'(stall), 0);
    chk("post_rst_fwd1", int'(fwd_rs1_sel), 0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rst_n         = ($urandom_range(0, 149) != 0);
      issue_valid   = ($urandom_range(0, 3) != 0);
      issue_rd_addr = 5'($urandom_range(0, 3));
      issue_rd_we   = 1'($urandom_range(0, 1));
      issue_is_load = 1'($urandom_range(0, 1));
      rs1_addr      = 5'($urandom_range(0, 3));
      rs2_addr      = 5'($urandom_range(0, 3));
      rs1_used      = 1'($urandom_range(0, 1));
      rs2_used      = 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(6);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of tracked stages between issue and writeback (legal range 1..8).
REQ-002 SHALL have parameter LOAD_READY_STAGE, default 2, meaning the first stage index at which load data may be forwarded (legal range 0..DEPTH-1).
REQ-003 SHALL have parameter FLUSH_STAGES, default 1, meaning the number of stage entries killed by a flush, in addition to the issuing instruction (legal range 0..DEPTH-1).
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the stall counter.
REQ-005 SHALL have local parameter SEL_W = $clog2(DEPTH+1).
REQ-006 clk  input  1  only clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 issue_valid  input  1  decoded instruction presented for issue.
REQ-009 issue_rd_addr  input  5  destination register.
REQ-010 issue_rd_we  input  1  instruction writes rd.
REQ-011 issue_is_load  input  1  rd value produced by memory stage.
REQ-012 rs1_addr, rs2_addr  input  5 each  source registers of the issuing instruction.
REQ-013 rs1_used, rs2_used  input  1 each  source operand is actually read.
REQ-014 flush  input  1  jump taken; kill younger instructions.
REQ-015 stall  output  1  combinational; issuing instruction is held and must be re-presented.
REQ-016 fwd_rs1_sel, fwd_rs2_sel  output  SEL_W each  combinational; 0 = register file, k = forward from stage k-1.
REQ-017 wb_valid, wb_rd_we  output  1 each  registered; entry leaving stage DEPTH-1.
REQ-018 wb_rd_addr  output  5  registered; rd of the writeback entry.
REQ-019 stall_count  output  CNT_W  registered saturating count of stall cycles.

Function
REQ-020 SHALL hold DEPTH entries {valid, rd_addr, rd_we, is_load}; stage 0 is youngest, stage DEPTH-1 oldest.
REQ-021 Every cycle, entry i SHALL move to i+1, and stage DEPTH-1 SHALL drive the wb_* outputs; there is no back-pressure.
REQ-022 An entry SHALL match rsN when: valid, rd_we, rd_addr != 0, rd_addr == rsN_addr, and rsN_used.
REQ-023 fwd_rsN_sel SHALL equal k+1 for the lowest matching stage index k, and SHALL equal 0 when no stage matches.
REQ-024 stall SHALL be 1 when issue_valid && !flush && the youngest match for rs1 or rs2 has is_load=1 with index < LOAD_READY_STAGE.
REQ-025 When stall=1, stage 0 SHALL load a bubble (valid=0); older entries still advance.
REQ-026 When issue_valid && !stall && !flush, stage 0 SHALL load {1, issue_rd_addr, issue_rd_we, issue_is_load}.
REQ-027 When issue_valid=0, stage 0 SHALL load a bubble.
REQ-028 On flush, stage 0 SHALL load a bubble, and entries shifting into stages 1..FLUSH_STAGES SHALL be invalidated; older entries shift normally.
REQ-029 flush SHALL override stall, which is forced to 0 during flush.
REQ-030 stall_count SHALL increment by 1 on each cycle with stall=1 and SHALL saturate at all-ones without wrapping.
REQ-031 rd_addr 0 SHALL never cause forwarding or a stall.

Reset
REQ-032 While rst_n=0, all entry valid bits, wb_valid, wb_rd_we, wb_rd_addr and stall_count SHALL be 0, asynchronously.
REQ-033 With rst_n=0, stall SHALL be 0 and fwd_rs1_sel and fwd_rs2_sel SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries; the first cycle after deassertion behaves as an empty pipeline.

Verification
REQ-035 Scenario: issue ALU op rd=5, then next cycle rs1=5 used -> fwd_rs1_sel=1, stall=0.
REQ-036 Scenario: issue load rd=7, then rs2=7 used (DEPTH=3, LOAD_READY_STAGE=2) -> stall=1 for 2 cycles, then fwd_rs2_sel=3; stall_count=2.
REQ-037 Scenario: two writers of rd=3 in stages 0 and 2, rs1=3 -> fwd_rs1_sel=1 (youngest wins).
REQ-038 Scenario: rd=0 writer in stage 0, rs1=0 -> fwd_rs1_sel=0, stall=0.
REQ-039 Scenario: flush with FLUSH_STAGES=1 while stages 0,1 valid -> next cycle stages 0,1 invalid, old stage 1 reaches stage 2 intact; a concurrent load-use stall reads stall=0.
REQ-040 Scenario: CNT_W=4, hold load-use stall 20 cycles -> stall_count stops at 15; rst_n pulse low mid-stream -> all outputs 0 immediately.
